po_run_sequencer: RTL and testbench

- Host-side initiator for the go/done handshake of the PO core (drives the core's go_i, watches its done).
- Launches a batch of N back-to-back core runs and measures the cycle count of each run.
- Runs a timeout watchdog that resets and recovers the core when it hangs.
- Sits between the host/test harness and the PO core top level; owns core_go_o and core_reset_o.

---
 rtl/po_run_sequencer_if.sv | 18 +
 rtl/po_run_sequencer.sv | 142 ++++++++++++++
 tb/tb_po_run_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/po_run_sequencer_if.sv
// rtl/po_run_sequencer_if.sv - go/done/recovery-reset handshake between the run sequencer and the PO core
interface po_run_sequencer_if;
  logic core_go_o;
  logic core_reset_o;
  logic core_done_i;

  modport master (
    output core_go_o,
    output core_reset_o,
    input  core_done_i
  );

  modport slave (
    input  core_go_o,
    input  core_reset_o,
    output core_done_i
  );
endinterface

// File: rtl/po_run_sequencer.sv
// rtl/po_run_sequencer.sv - launches batches of PO core runs, times each run, recovers hung runs
module po_run_sequencer #(
  parameter int CYCLE_W      = 32,
  parameter int TOTAL_W      = 40,
  parameter int RUNS_W       = 8,
  parameter int GO_CYCLES    = 1,
  parameter int RESET_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [RUNS_W-1:0]   num_runs_i,
  input  logic [CYCLE_W-1:0]  timeout_limit_i,
  po_run_sequencer_if.master  core,
  output logic                busy_o,
  output logic                run_valid_o,
  output logic [CYCLE_W-1:0]  run_cycles_o,
  output logic [RUNS_W-1:0]   run_index_o,
  output logic [TOTAL_W-1:0]  total_cycles_o,
  output logic                batch_done_o,
  output logic                timeout_o
);

  localparam int GO_W  = $clog2(GO_CYCLES + 1);
  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  localparam int SUM_W = TOTAL_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_GO, S_WAIT, S_REPORT, S_RECOVER} state_t;

  state_t state, state_next;

  logic               done_prev;
  logic [CYCLE_W-1:0] cyc;
  logic [CYCLE_W-1:0] limit;
  logic [RUNS_W-1:0]  num_runs;
  logic [RUNS_W-1:0]  run_idx;
  logic [GO_W-1:0]    go_cnt;
  logic [RST_W-1:0]   rst_cnt;

  logic               done_rise;
  logic               running;
  logic               last_run;
  logic               timed_out;
  logic               start_ok;
  logic [CYCLE_W-1:0] run_len;
  logic [SUM_W-1:0]   sum_ext;

  // A done level that was already high before this cycle never completes a run.
  assign done_rise = core.core_done_i & ~done_prev;
  assign running   = (state == S_GO) || (state == S_WAIT);
  assign start_ok  = (state == S_IDLE) && start_i;
  assign run_len   = cyc + CYCLE_W'(1);
  assign timed_out = (limit != '0) && (run_len == limit);
  assign last_run  = (run_idx + RUNS_W'(1)) == num_runs;
  assign sum_ext   = {1'b0, total_cycles_o} + SUM_W'(run_len);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start_i) state_next = S_GO;
      end
      // abort > done edge > watchdog
      S_GO, S_WAIT: begin
        if (abort_i)
          state_next = S_RECOVER;
        else if (done_rise)
          state_next = S_REPORT;
        else if (timed_out)
          state_next = S_RECOVER;
        else if ((state == S_GO) && (go_cnt == GO_W'(GO_CYCLES - 1)))
          state_next = S_WAIT;
      end
      S_REPORT: begin
        state_next = last_run ? S_IDLE : S_GO;
      end
      S_RECOVER: begin
        if (rst_cnt == RST_W'(RESET_CYCLES - 1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_prev         <= 1'b0;
      cyc               <= '0;
      limit             <= '0;
      num_runs          <= '0;
      run_idx           <= '0;
      go_cnt            <= '0;
      rst_cnt           <= '0;
      core.core_go_o    <= 1'b0;
      core.core_reset_o <= 1'b0;
      busy_o            <= 1'b0;
      run_valid_o       <= 1'b0;
      run_cycles_o      <= '0;
      run_index_o       <= '0;
      total_cycles_o    <= '0;
      batch_done_o      <= 1'b0;
      timeout_o         <= 1'b0;
    end else begin
      done_prev <= core.core_done_i;

      // Outputs are decoded from the next state so they line up with the state they describe.
      core.core_go_o    <= (state_next == S_GO);
      core.core_reset_o <= (state_next == S_RECOVER);
      busy_o            <= (state_next != S_IDLE);
      run_valid_o       <= (state_next == S_REPORT);
      batch_done_o      <= (state_next == S_REPORT) && last_run;

      go_cnt  <= (state == S_GO) ? go_cnt + GO_W'(1) : '0;
      rst_cnt <= (state == S_RECOVER) ? rst_cnt + RST_W'(1) : '0;
      cyc     <= running ? run_len : '0;

      if (start_ok) begin
        num_runs       <= (num_runs_i == '0) ? RUNS_W'(1) : num_runs_i;
        limit          <= timeout_limit_i;
        run_idx        <= '0;
        total_cycles_o <= '0;
        timeout_o      <= 1'b0;
      end

      if (running && (state_next == S_REPORT)) begin
        run_cycles_o   <= run_len;
        run_index_o    <= run_idx;
        total_cycles_o <= sum_ext[TOTAL_W] ? '1 : sum_ext[TOTAL_W-1:0];
      end

      if (running && (state_next == S_RECOVER)) timeout_o <= 1'b1;

      if ((state == S_REPORT) && !last_run) run_idx <= run_idx + RUNS_W'(1);
    end
  end

endmodule

// File: tb/tb_po_run_sequencer.sv
// tb/tb_po_run_sequencer.sv - scoreboard bench for po_run_sequencer with a latency-driven core model
module tb_po_run_sequencer;
  localparam int CYCLE_W = 32;
  localparam int TOTAL_W = 40;
  localparam int RUNS_W  = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start_i = 1'b0;
  logic               abort_i = 1'b0;
  logic [RUNS_W-1:0]  num_runs_i = '0;
  logic [CYCLE_W-1:0] timeout_limit_i = '0;
  logic               busy_o, run_valid_o, batch_done_o, timeout_o;
  logic [CYCLE_W-1:0] run_cycles_o;
  logic [RUNS_W-1:0]  run_index_o;
  logic [TOTAL_W-1:0] total_cycles_o;

  po_run_sequencer_if core();

  po_run_sequencer dut (
    .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
    .num_runs_i(num_runs_i), .timeout_limit_i(timeout_limit_i), .core(core),
    .busy_o(busy_o), .run_valid_o(run_valid_o), .run_cycles_o(run_cycles_o),
    .run_index_o(run_index_o), .total_cycles_o(total_cycles_o),
    .batch_done_o(batch_done_o), .timeout_o(timeout_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int     idx;
    longint cyc;
    longint tot;
    bit     last;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];
  int   core_lat[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;
  int   go_cyc = 0;
  int   done_cyc = 0;
  int   to_cyc = 0;
  int   batch_id = 0;
  int   ab_run = -1;
  int   ab_rem = 0;
  bit   stuck = 1'b0;
  int   bd_cnt = 0;
  int   rst_pulses = 0;
  int   last_rst_len = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name, input longint act);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected no such event", name, act);
  endfunction

  initial forever @(posedge clk) cyc_n++;

  // Core model: done rises a given number of cycles after the first go cycle and
  // falls again when the next go arrives; optionally fires abort_i at a chosen point.
  initial begin
    int rem, this_run, run_no, seen_batch;
    bit active, prev_go;
    core.core_done_i = 1'b0;
    rem = 0; this_run = 0; run_no = 0; seen_batch = 0; active = 0; prev_go = 0;
    forever begin
      @(negedge clk);
      abort_i = 1'b0;
      if (batch_id != seen_batch) begin
        seen_batch = batch_id;
        run_no = 0;
      end
      if (stuck) begin
        core.core_done_i = 1'b1;
      end else if (core.core_go_o && !prev_go) begin
        core.core_done_i = 1'b0;
        if (run_no > 0) check("go_spacing", longint'(cyc_n - done_cyc), 2);
        rem = (core_lat.size() > 0) ? core_lat.pop_front() : 1000;
        go_cyc = cyc_n;
        this_run = run_no;
        run_no++;
        active = 1;
      end else if (active) begin
        rem--;
        if (this_run == ab_run && rem == ab_rem) abort_i = 1'b1;
        if (rem == 0) begin
          core.core_done_i = 1'b1;
          done_cyc = cyc_n;
          active = 0;
        end
      end
      prev_go = core.core_go_o;
    end
  end

  // Monitor: pops the scoreboard on every report and tracks pulse shapes.
  initial begin
    exp_t e;
    bit prev_to, prev_bd;
    int go_len, rst_run;
    prev_to = 0; prev_bd = 0; go_len = 0; rst_run = 0;
    forever begin
      @(negedge clk);
      check("go_reset_exclusive", longint'(core.core_go_o & core.core_reset_o), 0);
      if (core.core_go_o) go_len++;
      else if (go_len > 0) begin
        check("go_len", longint'(go_len), 1);
        go_len = 0;
      end
      if (run_valid_o) begin
        if (exp_q.size() == 0) fail("unexpected_run_valid", longint'(run_index_o));
        else begin
          e = exp_q.pop_front();
          check("run_index", longint'(run_index_o), longint'(e.idx));
          check("run_cycles", longint'(run_cycles_o), e.cyc);
          check("total_cycles", longint'(total_cycles_o), e.tot);
          check("batch_done", longint'(batch_done_o), longint'(e.last));
        end
      end else if (batch_done_o) begin
        fail("batch_done_without_report", longint'(batch_done_o));
      end
      if (prev_bd) check("busy_low_after_batch", longint'(busy_o), 0);
      prev_bd = batch_done_o;
      bd_cnt += int'(batch_done_o);
      if (core.core_reset_o) rst_run++;
      else if (rst_run > 0) begin
        last_rst_len = rst_run;
        rst_run = 0;
        rst_pulses++;
      end
      if (timeout_o && !prev_to) to_cyc = cyc_n;
      prev_to = timeout_o;
    end
  end

  task automatic run_batch(input int n, input int lim, input bit stk, input int extra_start);
    int eff, bd0, rp0, guard;
    longint tot, len;
    bit err;
    eff = (n == 0) ? 1 : n;
    tot = 0;
    err = stk;
    if (!stk) begin
      for (int i = 0; i < eff; i++) begin
        len = longint'(lat_q[i]) + 1;
        if (i == ab_run || (lim != 0 && len > longint'(lim))) begin
          err = 1;
          break;
        end
        tot += len;
        exp_q.push_back('{i, len, tot, (i == eff - 1)});
      end
    end
    core_lat = lat_q;
    stuck = stk;
    batch_id++;
    bd0 = bd_cnt;
    rp0 = rst_pulses;
    @(negedge clk);
    if (stk) repeat (2) @(negedge clk);
    num_runs_i = RUNS_W'(n);
    timeout_limit_i = CYCLE_W'(lim);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    num_runs_i = RUNS_W'($urandom);
    timeout_limit_i = CYCLE_W'($urandom_range(1, 3));
    check("timeout_cleared_on_start", longint'(timeout_o), 0);
    check("busy_after_start", longint'(busy_o), 1);
    if (extra_start > 0) begin
      repeat (extra_start) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    guard = 0;
    while (busy_o && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (busy_o) fail("batch_never_finished", longint'(guard));
    repeat (2) @(negedge clk);
    check("scoreboard_drained", longint'(exp_q.size()), 0);
    exp_q.delete();
    check("timeout_flag", longint'(timeout_o), longint'(err));
    check("batch_done_count", longint'(bd_cnt - bd0), err ? 0 : 1);
    check("recover_pulses", longint'(rst_pulses - rp0), err ? 1 : 0);
    if (err) check("recover_len", longint'(last_rst_len), 4);
    stuck = 1'b0;
    ab_run = -1;
  endtask

  initial begin
    int n, eff, lim, rp0;
    repeat (3) @(negedge clk);
    check("reset_flags", longint'({core.core_go_o, core.core_reset_o, busy_o, run_valid_o, batch_done_o, timeout_o}), 0);
    check("reset_run_cycles", longint'(run_cycles_o), 0);
    check("reset_total", longint'(total_cycles_o), 0);
    reset = 1'b0;
    @(negedge clk);

    lat_q.delete(); lat_q.push_back(9);
    run_batch(1, 0, 0, 0);

    lat_q.delete(); lat_q.push_back(5); lat_q.push_back(7); lat_q.push_back(9);
    run_batch(3, 0, 0, 0);

    lat_q.delete(); lat_q.push_back(1000);
    run_batch(1, 20, 0, 0);
    check("timeout_latency", longint'(to_cyc - go_cyc), 20);

    lat_q.delete(); lat_q.push_back(4);
    run_batch(1, 0, 0, 0);

    lat_q.delete();
    run_batch(1, 15, 1, 0);

    lat_q.delete(); lat_q.push_back(19);
    run_batch(1, 20, 0, 0);

    lat_q.delete(); lat_q.push_back(8);
    ab_run = 0; ab_rem = 0;
    run_batch(1, 0, 0, 0);

    lat_q.delete(); lat_q.push_back(6);
    run_batch(0, 0, 0, 0);

    lat_q.delete(); lat_q.push_back(30);
    run_batch(1, 0, 0, 8);

    // reset in the middle of a WAIT
    lat_q.delete(); lat_q.push_back(1000);
    core_lat = lat_q;
    batch_id++;
    rp0 = rst_pulses;
    @(negedge clk);
    num_runs_i = RUNS_W'(2); timeout_limit_i = '0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_before_reset", longint'(busy_o), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_flags", longint'({core.core_go_o, core.core_reset_o, busy_o, run_valid_o, batch_done_o, timeout_o}), 0);
    check("midrun_reset_run_cycles", longint'(run_cycles_o), 0);
    check("midrun_reset_run_index", longint'(run_index_o), 0);
    check("midrun_reset_total", longint'(total_cycles_o), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_reset_no_core_pulse", longint'(rst_pulses - rp0), 0);
    exp_q.delete();

    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 4);
      eff = (n == 0) ? 1 : n;
      lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 40);
      lat_q.delete();
      for (int k = 0; k < eff; k++) lat_q.push_back($urandom_range(1, 40));
      if ($urandom_range(0, 3) == 0) begin
        ab_run = $urandom_range(0, eff - 1);
        ab_rem = $urandom_range(0, lat_q[ab_run] - 1);
      end else begin
        ab_run = -1;
      end
      run_batch(n, lim, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got %0d cycles expected completion", cyc_n);
    $fatal(1, "time limit");
  end

endmodule
